pipe_bypass_ctrl: RTL

Parametrised in-flight register tracker for the core pipeline. It replaces the fixed two-source EX/MEM/WB forwarding and load-use hazard logic with one block that supports:
- a configurable number of post-issue stages and load-data latency;
- a downstream `hold`, flush and a stall counter.

It sits between decode and execute. Decode presents source/destination info, and the block returns bypassed operand values, an issue stall and the register-file write-back.

---
 rtl/pipe_bypass_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/pipe_bypass_ctrl.sv
// In-flight destination tracker between decode and execute: operand bypass, load-use
// interlock, write-back sequencing and a saturating hazard-stall counter.
module pipe_bypass_ctrl #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned RF_ADDRESS = 5,
    parameter int unsigned STAGES     = 3,
    parameter int unsigned LOAD_STAGE = 2,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  issue_valid,
    input  logic [RF_ADDRESS-1:0] issue_rs1,
    input  logic [RF_ADDRESS-1:0] issue_rs2,
    input  logic                  issue_use_rs1,
    input  logic                  issue_use_rs2,
    input  logic [RF_ADDRESS-1:0] issue_rd,
    input  logic                  issue_regwrite,
    input  logic                  issue_is_load,
    input  logic [DATA_W-1:0]     rf_rs1_data,
    input  logic [DATA_W-1:0]     rf_rs2_data,
    input  logic [DATA_W-1:0]     ex_result,
    input  logic [DATA_W-1:0]     load_data,
    input  logic                  flush,
    input  logic                  hold,
    output logic                  issue_ready,
    output logic [DATA_W-1:0]     op1_data,
    output logic [DATA_W-1:0]     op2_data,
    output logic                  wb_en,
    output logic [RF_ADDRESS-1:0] wb_rd,
    output logic [DATA_W-1:0]     wb_data,
    output logic [CNT_W-1:0]      stall_cycles
);

    localparam int NumStages = int'(STAGES);
    localparam int LoadStage = int'(LOAD_STAGE);

    logic                  valid_q    [1:NumStages];
    logic                  valid_d    [1:NumStages];
    logic [RF_ADDRESS-1:0] rd_q       [1:NumStages];
    logic [RF_ADDRESS-1:0] rd_d       [1:NumStages];
    logic                  regwrite_q [1:NumStages];
    logic                  regwrite_d [1:NumStages];
    logic                  is_load_q  [1:NumStages];
    logic                  is_load_d  [1:NumStages];
    logic [DATA_W-1:0]     data_q     [1:NumStages];
    logic [DATA_W-1:0]     data_d     [1:NumStages];
    logic                  ready_q    [1:NumStages];
    logic                  ready_d    [1:NumStages];

    logic [CNT_W-1:0]      stall_q;
    logic [CNT_W-1:0]      stall_d;

    logic [RF_ADDRESS-1:0] src_addr [2];
    logic [DATA_W-1:0]     src_rf   [2];
    logic [DATA_W-1:0]     src_val  [2];
    logic                  src_haz  [2];
    logic                  hazard;
    logic                  accept;

    always_comb begin
        src_addr[0] = issue_rs1;
        src_addr[1] = issue_rs2;
        src_rf[0]   = rf_rs1_data;
        src_rf[1]   = rf_rs2_data;
    end

    // Walk oldest to youngest so the youngest matching entry overwrites older ones.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            src_val[i] = src_rf[i];
            src_haz[i] = 1'b0;
            for (int s = NumStages; s >= 1; s--) begin
                if (valid_q[s] && regwrite_q[s] && (rd_q[s] == src_addr[i]) &&
                    (src_addr[i] != '0)) begin
                    src_haz[i] = is_load_q[s] && (s < LoadStage);
                    if ((s == 1) && !is_load_q[s]) begin
                        src_val[i] = ex_result;
                    end else if ((s == LoadStage) && is_load_q[s]) begin
                        src_val[i] = load_data;
                    end else if (ready_q[s]) begin
                        src_val[i] = data_q[s];
                    end else begin
                        src_val[i] = src_rf[i];
                    end
                end
            end
        end
    end

    always_comb begin
        hazard      = (issue_use_rs1 && src_haz[0]) || (issue_use_rs2 && src_haz[1]);
        issue_ready = !hazard && !hold;
        accept      = issue_valid && issue_ready && !flush;
        op1_data    = src_val[0];
        op2_data    = src_val[1];
    end

    always_comb begin
        for (int s = 1; s <= NumStages; s++) begin
            valid_d[s]    = valid_q[s];
            rd_d[s]       = rd_q[s];
            regwrite_d[s] = regwrite_q[s];
            is_load_d[s]  = is_load_q[s];
            data_d[s]     = data_q[s];
            ready_d[s]    = ready_q[s];
        end
        if (!hold) begin
            for (int s = NumStages; s >= 2; s--) begin
                valid_d[s]    = valid_q[s-1];
                rd_d[s]       = rd_q[s-1];
                regwrite_d[s] = regwrite_q[s-1];
                is_load_d[s]  = is_load_q[s-1];
                if ((s - 1 == 1) && !is_load_q[s-1]) begin
                    data_d[s]  = ex_result;
                    ready_d[s] = 1'b1;
                end else if ((s - 1 == LoadStage) && is_load_q[s-1]) begin
                    data_d[s]  = load_data;
                    ready_d[s] = 1'b1;
                end else begin
                    data_d[s]  = data_q[s-1];
                    ready_d[s] = ready_q[s-1];
                end
            end
            valid_d[1]    = accept;
            rd_d[1]       = issue_rd;
            regwrite_d[1] = issue_regwrite;
            is_load_d[1]  = issue_is_load;
            data_d[1]     = '0;
            ready_d[1]    = 1'b0;
        end else if (flush) begin
            // A redirect during a freeze still kills the youngest entry.
            valid_d[1] = 1'b0;
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (!hold && issue_valid && hazard && !flush && (stall_q != '1)) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 1; s <= NumStages; s++) begin
                valid_q[s]    <= 1'b0;
                rd_q[s]       <= '0;
                regwrite_q[s] <= 1'b0;
                is_load_q[s]  <= 1'b0;
                data_q[s]     <= '0;
                ready_q[s]    <= 1'b0;
            end
            stall_q <= '0;
        end else begin
            for (int s = 1; s <= NumStages; s++) begin
                valid_q[s]    <= valid_d[s];
                rd_q[s]       <= rd_d[s];
                regwrite_q[s] <= regwrite_d[s];
                is_load_q[s]  <= is_load_d[s];
                data_q[s]     <= data_d[s];
                ready_q[s]    <= ready_d[s];
            end
            stall_q <= stall_d;
        end
    end

    always_comb begin
        wb_en        = valid_q[NumStages] && regwrite_q[NumStages] &&
                       (rd_q[NumStages] != '0) && !hold;
        wb_rd        = rd_q[NumStages];
        wb_data      = data_q[NumStages];
        stall_cycles = stall_q;
    end

endmodule
